cfo_corr_acc: RTL and testbench
===============================

Name: cfo_corr_acc

Overview:
- Delay-and-correlate accumulator for CFO estimation; sits directly downstream of the window counter (`up_cnt`).
- Drives the counter's enable and reset, and consumes its terminal-count flag `cntf`.
- Computes z = Σ x[n]·conj(x[n−DLY]) over the counted window.
- Presents z (I/Q) with a one-cycle valid pulse to the angle/CORDIC stage.

Parameters:
- DW, 12, input sample width per rail (signed two's complement)
- DLY, 16, correlation lag in samples (STF period); ≥2
- ACC_W, 32, accumulator width per rail (signed); ≥ 2*DW+2

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low
- start  in  1  one-cycle pulse from packet detector; begins a measurement
- abort  in  1  synchronous abort; returns to IDLE without output
- in_valid  in  1  sample strobe
- in_i  in  DW  sample real part, signed
- in_q  in  DW  sample imaginary part, signed
- cntf  in  1  terminal-count flag from window counter
- cnt_en  out  1  window counter enable
- cnt_rst  out  1  window counter synchronous reset, active-high
- acc_i  out  ACC_W  Re(z), signed
- acc_q  out  ACC_W  Im(z), signed
- out_valid  out  1  one-cycle pulse, acc_i/acc_q valid
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE; delay line, fill counter, product regs and accumulators = 0; acc_i=acc_q=0; out_valid=0; cnt_en=0; cnt_rst=1; busy=0.
- FSM states: IDLE, FILL, ACC, FLUSH, DONE.
- IDLE:
  - cnt_rst=1.
  - start → FILL; clears accumulators, fill counter and delay line.
  - in_valid in the start cycle is not captured.
- FILL:
  - Each in_valid shifts (in_i,in_q) into the DLY-deep delay line and increments the fill counter.
  - After the DLY-th valid sample → ACC.
  - cnt_en=0; cnt_rst=0.
- ACC:
  - Each in_valid shifts the delay line and registers the product with the delayed sample d = x[n−DLY]:
    - p_re = i_n·i_d + q_n·q_d
    - p_im = q_n·i_d − i_n·q_d
    - Full precision, 2*DW+1 bits, sign-extended to ACC_W.
  - cnt_en = in_valid.
  - The registered product is added to the accumulator one cycle later (product-valid flag).
  - in_valid && cntf → FLUSH; that sample is the last one accumulated.
- FLUSH: one cycle; the final pending product is added; in_valid ignored; cnt_en=0.
- DONE:
  - out_valid=1 for exactly one cycle; cnt_rst=1.
  - acc_i/acc_q hold the result until the next start.
  - Next state IDLE.
- Latency: out_valid asserts 2 cycles after the in_valid&&cntf cycle.
- Window length: number of in_valid samples in ACC up to and including the cntf sample (counter-defined).
- Overflow without the optional feature: two's-complement wrap modulo 2^ACC_W.
- start while busy: ignored.
- abort:
  - Any state → IDLE next cycle.
  - No out_valid; acc_i/acc_q keep their previous values.
  - Has priority over start, cntf and in_valid.
- cntf high in FILL: ignored.
- in_valid gaps: no state advance and no accumulation on idle cycles.

Optional Feature:
- Macro: CFO_ACC_SAT_EN.
- Defined: each accumulator add saturates to [−2^(ACC_W−1), 2^(ACC_W−1)−1] per rail. A sticky internal sat flag ORs into bit 0 of nothing; instead an extra output port `sat` (1 bit) is added, cleared on start and set on any clip.
- Undefined: wrap arithmetic and no `sat` port.

Decomposition:
- Package cfo_pkg: state enum (IDLE, FILL, ACC, FLUSH, DONE), default DW/DLY/ACC_W constants, and a product-width function (2*DW+1).
- Sub-module cfo_delay_line:
  - Parameterised DW/DLY shift register with shift enable and synchronous clear.
  - Output is the sample delayed by DLY shifts.
  - Async active-low reset.

Test Plan:
- Constant x=(100,0), DLY=16, counter terminating after 10 ACC samples → acc_i=100000, acc_q=0, out_valid single pulse 2 cycles after last sample, cnt_rst high in DONE.
- 16 samples (100,0) then 16 samples (0,100), window 16 → acc_i=0, acc_q=160000.
- Same as the first case but in_valid toggling every other cycle → identical result; cnt_en only on valid cycles.
- abort asserted mid-ACC → IDLE next cycle; no out_valid; busy=0; a subsequent start runs a clean measurement with the correct result.
- rst pulled low mid-FILL (asynchronous, between edges) → all outputs take reset values immediately; start pulse during a busy run → ignored, result unchanged.
- CFO_ACC_SAT_EN with ACC_W=20, x=(2047,0), 64 samples → acc_i=524287 and sat=1; without the macro → the wrapped value.

Source files
------------

// File: rtl/cfo_pkg.sv
// Shared types and defaults for the CFO delay-and-correlate accumulator.
// Optional saturation is enabled with CFO_ACC_SAT_EN.
package cfo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    ACC,
    FLUSH,
    DONE
  } state_t;

  localparam int DEF_DW    = 12;
  localparam int DEF_DLY   = 16;
  localparam int DEF_ACC_W = 32;

  function automatic int prod_w(input int dw);
    return 2 * dw + 1;
  endfunction

endpackage

// File: rtl/cfo_delay_line.sv
// DLY-deep complex sample shift register with enable and sync clear.
// Output is the sample shifted in DLY enables ago.
module cfo_delay_line
  import cfo_pkg::*;
#(
  parameter int DW  = DEF_DW,
  parameter int DLY = DEF_DLY
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic signed [DW-1:0] din_i,
  input  logic signed [DW-1:0] din_q,
  output logic signed [DW-1:0] dout_i,
  output logic signed [DW-1:0] dout_q
);

  logic signed [DW-1:0] li [DLY];
  logic signed [DW-1:0] lq [DLY];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DLY; k++) begin
        li[k] <= '0;
        lq[k] <= '0;
      end
    end else if (clr) begin
      for (int k = 0; k < DLY; k++) begin
        li[k] <= '0;
        lq[k] <= '0;
      end
    end else if (en) begin
      li[0] <= din_i;
      lq[0] <= din_q;
      for (int k = 1; k < DLY; k++) begin
        li[k] <= li[k-1];
        lq[k] <= lq[k-1];
      end
    end
  end

  assign dout_i = li[DLY-1];
  assign dout_q = lq[DLY-1];

endmodule

// File: rtl/cfo_corr_acc.sv
// Delay-and-correlate accumulator z = sum x[n]*conj(x[n-DLY]) for CFO.
// Define CFO_ACC_SAT_EN for saturating adds and a sticky sat output.
module cfo_corr_acc
  import cfo_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int DLY   = DEF_DLY,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    in_valid,
  input  logic signed [DW-1:0]    in_i,
  input  logic signed [DW-1:0]    in_q,
  input  logic                    cntf,
  output logic                    cnt_en,
  output logic                    cnt_rst,
  output logic signed [ACC_W-1:0] acc_i,
  output logic signed [ACC_W-1:0] acc_q,
  output logic                    out_valid,
  output logic                    busy
`ifdef CFO_ACC_SAT_EN
  ,
  output logic                    sat
`endif
);

  localparam int PW = prod_w(DW);
  localparam int FW = $clog2(DLY + 1);

  state_t st;

  logic [FW-1:0] fcnt;
  logic          pv;
  logic          go;
  logic          shift;

  logic signed [PW-1:0] pr;
  logic signed [PW-1:0] pi;
  logic signed [PW-1:0] pe_r;
  logic signed [PW-1:0] pe_i;
  logic signed [PW-1:0] m_re;
  logic signed [PW-1:0] m_im;
  logic signed [PW-1:0] xi;
  logic signed [PW-1:0] xq;
  logic signed [PW-1:0] yi;
  logic signed [PW-1:0] yq;

  logic signed [DW-1:0] d_i;
  logic signed [DW-1:0] d_q;

  logic signed [ACC_W-1:0] sum_i;
  logic signed [ACC_W-1:0] sum_q;
  logic signed [ACC_W-1:0] nx_i;
  logic signed [ACC_W-1:0] nx_q;

  assign go    = (st == IDLE) && start && !abort;
  assign shift = in_valid && !abort && (st == FILL || st == ACC);

  cfo_delay_line #(
    .DW  (DW),
    .DLY (DLY)
  ) u_dly (
    .clk    (clk),
    .rst    (rst),
    .en     (shift),
    .clr    (go),
    .din_i  (in_i),
    .din_q  (in_q),
    .dout_i (d_i),
    .dout_q (d_q)
  );

  assign xi = PW'(in_i);
  assign xq = PW'(in_q);
  assign yi = PW'(d_i);
  assign yq = PW'(d_q);

  assign m_re = xi * yi + xq * yq;
  assign m_im = xq * yi - xi * yq;

  assign pe_r = pv ? pr : '0;
  assign pe_i = pv ? pi : '0;

`ifdef CFO_ACC_SAT_EN
  // Add in a width wide enough for both operands, then clip to ACC_W.
  localparam int SW = ((ACC_W > PW) ? ACC_W : PW) + 1;

  localparam logic signed [SW-1:0] SMAX =
    {{(SW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN =
    {{(SW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  logic signed [SW-1:0] ws_i;
  logic signed [SW-1:0] ws_q;
  logic                 clip;
  logic                 sat_r;

  assign ws_i = SW'(sum_i) + SW'(pe_r);
  assign ws_q = SW'(sum_q) + SW'(pe_i);

  always_comb begin
    nx_i = ws_i[ACC_W-1:0];
    nx_q = ws_q[ACC_W-1:0];
    clip = 1'b0;
    if (ws_i > SMAX) begin
      nx_i = SMAX[ACC_W-1:0];
      clip = 1'b1;
    end else if (ws_i < SMIN) begin
      nx_i = SMIN[ACC_W-1:0];
      clip = 1'b1;
    end
    if (ws_q > SMAX) begin
      nx_q = SMAX[ACC_W-1:0];
      clip = 1'b1;
    end else if (ws_q < SMIN) begin
      nx_q = SMIN[ACC_W-1:0];
      clip = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_r <= 1'b0;
    end else if (go) begin
      sat_r <= 1'b0;
    end else if (pv && clip) begin
      sat_r <= 1'b1;
    end
  end

  assign sat = sat_r;
`else
  assign nx_i = sum_i + ACC_W'(pe_r);
  assign nx_q = sum_q + ACC_W'(pe_i);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st    <= IDLE;
      fcnt  <= '0;
      pv    <= 1'b0;
      pr    <= '0;
      pi    <= '0;
      sum_i <= '0;
      sum_q <= '0;
      acc_i <= '0;
      acc_q <= '0;
    end else begin
      pv <= 1'b0;
      if (pv) begin
        sum_i <= nx_i;
        sum_q <= nx_q;
      end
      if (abort) begin
        st <= IDLE;
      end else begin
        unique case (st)
          IDLE: begin
            if (start) begin
              st    <= FILL;
              fcnt  <= '0;
              sum_i <= '0;
              sum_q <= '0;
            end
          end
          FILL: begin
            if (in_valid) begin
              fcnt <= fcnt + 1'b1;
              if (fcnt == FW'(DLY - 1))
                st <= ACC;
            end
          end
          ACC: begin
            if (in_valid) begin
              pr <= m_re;
              pi <= m_im;
              pv <= 1'b1;
              if (cntf)
                st <= FLUSH;
            end
          end
          FLUSH: begin
            acc_i <= nx_i;
            acc_q <= nx_q;
            st    <= DONE;
          end
          DONE: st <= IDLE;
          default: st <= IDLE;
        endcase
      end
    end
  end

  assign out_valid = (st == DONE);
  assign busy      = (st != IDLE);
  assign cnt_rst   = (st == IDLE) || (st == DONE);
  assign cnt_en    = (st == ACC) && in_valid;

endmodule

// File: tb/tb_cfo_corr_acc.sv
// Directed bench for cfo_corr_acc with a behavioural window counter.
// A second instance with ACC_W=20 exercises wrap / saturation.
module tb_cfo_corr_acc;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic in_valid = 1'b0;
  logic signed [11:0] in_i = '0;
  logic signed [11:0] in_q = '0;
  logic cntf;

  logic cnt_en, cnt_rst, out_valid, busy;
  logic signed [31:0] acc_i, acc_q;
  logic n_en, n_rst, n_ov, n_busy;
  logic signed [19:0] n_i, n_q;
`ifdef CFO_ACC_SAT_EN
  logic sat, n_sat;
`endif

  int total = 0;
  int bad = 0;
  int cnt = 0;
  int win = 1;

  typedef struct {
    int     fi, fq, ai, aq, win;
    bit     gap;
    longint ei, eq, eni, enq;
    bit     esat;
  } vec_t;

  vec_t tv[5];

  always #5 clk = ~clk;

  cfo_corr_acc dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_i(in_i), .in_q(in_q), .cntf(cntf),
    .cnt_en(cnt_en), .cnt_rst(cnt_rst), .acc_i(acc_i), .acc_q(acc_q),
    .out_valid(out_valid), .busy(busy)
`ifdef CFO_ACC_SAT_EN
    , .sat(sat)
`endif
  );

  cfo_corr_acc #(.DW(12), .DLY(16), .ACC_W(20)) dut_n (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_i(in_i), .in_q(in_q), .cntf(cntf),
    .cnt_en(n_en), .cnt_rst(n_rst), .acc_i(n_i), .acc_q(n_q),
    .out_valid(n_ov), .busy(n_busy)
`ifdef CFO_ACC_SAT_EN
    , .sat(n_sat)
`endif
  );

  // Behavioural up_cnt: terminal flag on the win-th enabled sample.
  always @(posedge clk or negedge rst) begin
    if (!rst) cnt <= 0;
    else if (cnt_rst) cnt <= 0;
    else if (cnt_en) cnt <= cnt + 1;
  end
  assign cntf = (cnt == win - 1);

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input vec_t v, input bit mid_start, input longint prev_i);
    bit enbad;
    enbad = 1'b0;
    win = v.win;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_fill", busy, 1);
    chk("cnt_rst_fill", cnt_rst, 0);
    for (int k = 0; k < 16; k++) begin
      if (v.gap) begin
        in_valid = 1'b0;
        step();
      end
      in_valid = 1'b1;
      in_i = 12'(v.fi);
      in_q = 12'(v.fq);
      step();
    end
    for (int k = 0; k < v.win; k++) begin
      if (v.gap) begin
        in_valid = 1'b0;
        #1;
        if (cnt_en !== 1'b0) enbad = 1'b1;
        step();
      end
      in_valid = 1'b1;
      in_i = 12'(v.ai);
      in_q = 12'(v.aq);
      start = mid_start && (k == 2);
      #1;
      if (cnt_en !== 1'b1) enbad = 1'b1;
      step();
      start = 1'b0;
    end
    in_valid = 1'b0;
    chk("cnt_en_pattern", enbad, 0);
    chk("ov_flush", out_valid, 0);
    chk("acc_i_before_done", acc_i, prev_i);
    step();
    chk("ov_done", out_valid, 1);
    chk("cnt_rst_done", cnt_rst, 1);
    chk("acc_i", acc_i, v.ei);
    chk("acc_q", acc_q, v.eq);
    chk("n_acc_i", n_i, v.eni);
    chk("n_acc_q", n_q, v.enq);
    chk("n_ov_done", n_ov, 1);
`ifdef CFO_ACC_SAT_EN
    chk("sat_wide", sat, 0);
    chk("sat_narrow", n_sat, v.esat);
`endif
    step();
    chk("ov_pulse", out_valid, 0);
    chk("busy_idle", busy, 0);
    chk("acc_i_hold", acc_i, v.ei);
  endtask

  initial begin
    tv[0] = '{100, 0, 100, 0, 10, 1'b0, 100000, 0, 100000, 0, 1'b0};
    tv[1] = '{100, 0, 0, 100, 16, 1'b0, 0, 160000, 0, 160000, 1'b0};
    tv[2] = '{100, 0, 100, 0, 10, 1'b1, 100000, 0, 100000, 0, 1'b0};
    tv[3] = '{2047, 0, 2047, 0, 48, 1'b0, 0, 0, 0, 0, 1'b0};
    tv[4] = '{-50, 30, 20, -40, 5, 1'b0, -11000, 7000, -11000, 7000, 1'b0};
    // 64 samples of (2047,0): 16 fill plus a 48-sample window.
    tv[3].ei = 48 * 4190209;
`ifdef CFO_ACC_SAT_EN
    tv[3].eni = 524287;
    tv[3].esat = 1'b1;
`else
    tv[3].eni = -196560;
`endif

    #13;
    chk("rst_cnt_rst", cnt_rst, 1);
    chk("rst_cnt_en", cnt_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_acc_i", acc_i, 0);
    chk("rst_acc_q", acc_q, 0);
    @(negedge clk);
    rst = 1'b1;
    step();

    run(tv[0], 1'b0, 0);
    for (int t = 1; t < 5; t++) run(tv[t], 1'b0, tv[t-1].ei);

    // Abort in the middle of the accumulate phase.
    win = 10;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 19; k++) begin
      in_valid = 1'b1;
      in_i = 12'sd100;
      in_q = 12'sd0;
      step();
    end
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_ov", out_valid, 0);
    chk("abort_acc_i", acc_i, tv[4].ei);
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (out_valid) seen = 1'b1;
        step();
      end
      chk("abort_no_ov", seen, 0);
    end
    run(tv[0], 1'b0, tv[4].ei);

    // Asynchronous reset between clock edges while filling.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_i = 12'sd7;
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_cnt_rst", cnt_rst, 1);
    chk("arst_acc_i", acc_i, 0);
    chk("arst_ov", out_valid, 0);
    step();
    rst = 1'b1;
    step();

    // A start pulse during accumulation must not disturb the run.
    run(tv[0], 1'b1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
